// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: one outstanding cache read feeding
// a FIFO_DEPTH-entry {pc, instr} prefetch queue toward ID.
module if_prefetch_unit #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h00000060,
  parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        redirect_valid,
  input  logic [31:0]                 redirect_pc,
  input  logic                        id_ready,
  output logic                        if_valid,
  output logic [31:0]                 if_pc,
  output logic [31:0]                 if_instr,
  output logic                        inst_read,
  output logic [31:0]                 inst_addr,
  input  logic                        inst_resp,
  input  logic [31:0]                 inst_rdata,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   fetch_pc_nxt;
  logic [31:0]   addr_nxt;
  logic [31:0]   redir_pc;
  logic [31:0]   next_addr;
  logic [31:0]   pc_q    [FIFO_DEPTH];
  logic [31:0]   instr_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] count_after;
  logic          push;
  logic          pop;
  logic          flush;

  assign redir_pc    = redirect_pc & ~32'h3;
  assign next_addr   = inst_addr + 32'd4;
  assign flush       = redirect_valid;
  assign if_valid    = (count != '0);
  assign pop         = if_valid && id_ready && !flush;
  assign count_after = count + CW'(1) - CW'(pop);
  assign inst_read   = (state == REQ) || (state == DISCARD);
  assign fifo_count  = count;
  assign if_pc       = if_valid ? pc_q[rd_ptr] : '0;
  assign if_instr    = if_valid ? instr_q[rd_ptr] : NOP_INSTR;

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    addr_nxt     = inst_addr;
    push         = 1'b0;
    unique case (state)
      IDLE: begin
        if (flush) begin
          fetch_pc_nxt = redir_pc;
        end else if (count < FULL) begin
          state_nxt = REQ;
          addr_nxt  = fetch_pc;
        end
      end
      REQ: begin
        if (flush) begin
          fetch_pc_nxt = redir_pc;
          state_nxt    = inst_resp ? IDLE : DISCARD;
        end else if (inst_resp) begin
          push         = 1'b1;
          fetch_pc_nxt = next_addr;
          // slot was reserved at issue; keep streaming only if one is left
          if (count_after < FULL) begin
            addr_nxt = next_addr;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DISCARD: begin
        if (flush) begin
          fetch_pc_nxt = redir_pc;
        end
        if (inst_resp) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    count_nxt = count + CW'(push) - CW'(pop);
    if (flush) begin
      count_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      inst_addr <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      state     <= state_nxt;
      fetch_pc  <= fetch_pc_nxt;
      inst_addr <= addr_nxt;
      count     <= count_nxt;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr]    <= inst_addr;
      instr_q[wr_ptr] <= inst_rdata;
    end
  end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit with a latency-programmable
// instruction-cache responder driven once per cycle.
module tb_if_prefetch_unit;

  localparam logic [31:0] KEY = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        inst_read;
  logic [31:0] inst_addr;
  logic        inst_resp;
  logic [31:0] inst_rdata;
  logic [2:0]  fifo_count;

  int checks   = 0;
  int passed   = 0;
  int lat      = 0;
  int wait_cnt = 0;

  always #5 clk = ~clk;

  if_prefetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_ready      (id_ready),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .inst_read     (inst_read),
    .inst_addr     (inst_addr),
    .inst_resp     (inst_resp),
    .inst_rdata    (inst_rdata),
    .fifo_count    (fifo_count)
  );

  // Cache answers after inst_read has been high for lat cycles.
  task automatic tick();
    @(posedge clk);
    #1;
    if (inst_read) begin
      if (wait_cnt >= lat) begin
        inst_resp  = 1'b1;
        inst_rdata = inst_addr ^ KEY;
        wait_cnt   = 0;
      end else begin
        inst_resp = 1'b0;
        wait_cnt++;
      end
    end else begin
      inst_resp = 1'b0;
      wait_cnt  = 0;
    end
  endtask

  task automatic do_reset(input int l, input logic rdy);
    lat            = l;
    id_ready       = rdy;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    rst            = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(0, 1'b1);
    checks++;
    if (if_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", if_valid);
    else passed++;
    checks++;
    if (if_pc !== 32'h0) $display("FAIL rst_pc got %h exp 0", if_pc);
    else passed++;
    checks++;
    if (if_instr !== 32'h13) $display("FAIL rst_instr got %h exp 13", if_instr);
    else passed++;
    checks++;
    if (inst_read !== 1'b0) $display("FAIL rst_read got %b exp 0", inst_read);
    else passed++;
    checks++;
    if (inst_addr !== 32'h0) $display("FAIL rst_addr got %h exp 0", inst_addr);
    else passed++;
    checks++;
    if (fifo_count !== 3'd0) $display("FAIL rst_count got %0d exp 0", fifo_count);
    else passed++;
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    do_reset(0, 1'b1);
    tick();
    checks++;
    if (!(inst_read === 1'b1 && inst_addr === 32'h60))
      $display("FAIL stream_first rd %b addr %h exp 1 60", inst_read, inst_addr);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp = 32'h60 + 32'(4 * i);
      checks++;
      if (!(if_valid === 1'b1 && if_pc === exp))
        $display("FAIL stream_pc v %b pc %h exp %h", if_valid, if_pc, exp);
      else passed++;
      checks++;
      if (if_instr !== (exp ^ KEY))
        $display("FAIL stream_instr got %h exp %h", if_instr, exp ^ KEY);
      else passed++;
      checks++;
      if (inst_addr !== exp + 32'd4)
        $display("FAIL stream_addr got %h exp %h", inst_addr, exp + 32'd4);
      else passed++;
      checks++;
      if (fifo_count !== 3'd1)
        $display("FAIL stream_count got %0d exp 1", fifo_count);
      else passed++;
    end
  endtask

  task automatic test_stall();
    int n;
    logic [31:0] exp;
    do_reset(0, 1'b0);
    n = 0;
    while (fifo_count !== 3'd4 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (fifo_count !== 3'd4) $display("FAIL stall_fill got %0d exp 4", fifo_count);
    else passed++;
    tick();
    tick();
    checks++;
    if (!(fifo_count === 3'd4 && inst_read === 1'b0))
      $display("FAIL stall_hold cnt %0d rd %b exp 4 0", fifo_count, inst_read);
    else passed++;
    id_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp = 32'h60 + 32'(4 * i);
      checks++;
      if (!(if_valid === 1'b1 && if_pc === exp))
        $display("FAIL stall_drain v %b pc %h exp %h", if_valid, if_pc, exp);
      else passed++;
      if (i >= 2) begin
        checks++;
        if (fifo_count !== 3'd2)
          $display("FAIL stall_pp_count got %0d exp 2", fifo_count);
        else passed++;
      end
      if (i == 2) begin
        checks++;
        if (!(inst_read === 1'b1 && inst_addr === 32'h70))
          $display("FAIL stall_resume rd %b addr %h exp 1 70", inst_read, inst_addr);
        else passed++;
      end
      tick();
    end
  endtask

  task automatic test_redirect_pending();
    int n;
    logic stale;
    do_reset(3, 1'b0);
    n = 0;
    while (!(if_valid === 1'b1 && inst_read === 1'b1 && inst_addr === 32'h64) && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (!(if_valid === 1'b1 && inst_addr === 32'h64))
      $display("FAIL rp_setup v %b addr %h exp 1 64", if_valid, inst_addr);
    else passed++;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h123;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (!(fifo_count === 3'd0 && if_valid === 1'b0))
      $display("FAIL rp_flush cnt %0d v %b exp 0 0", fifo_count, if_valid);
    else passed++;
    checks++;
    if (!(inst_read === 1'b1 && inst_addr === 32'h64))
      $display("FAIL rp_stale_hold rd %b addr %h exp 1 64", inst_read, inst_addr);
    else passed++;
    id_ready = 1'b1;
    stale    = 1'b0;
    n        = 0;
    while (!(inst_read === 1'b1 && inst_addr === 32'h120) && n < 20) begin
      if (if_valid === 1'b1) stale = 1'b1;
      tick();
      n++;
    end
    checks++;
    if (stale !== 1'b0) $display("FAIL rp_stale_seen got %b exp 0", stale);
    else passed++;
    checks++;
    if (!(inst_read === 1'b1 && inst_addr === 32'h120))
      $display("FAIL rp_new_addr rd %b addr %h exp 1 120", inst_read, inst_addr);
    else passed++;
    n = 0;
    while (if_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (!(if_valid === 1'b1 && if_pc === 32'h120 && if_instr === (32'h120 ^ KEY)))
      $display("FAIL rp_first v %b pc %h ins %h exp 1 120", if_valid, if_pc, if_instr);
    else passed++;
  endtask

  task automatic test_redirect_resp();
    int n;
    do_reset(0, 1'b1);
    n = 0;
    while (!(inst_read === 1'b1 && inst_addr === 32'h68) && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!(inst_resp === 1'b1 && inst_addr === 32'h68))
      $display("FAIL rr_setup resp %b addr %h exp 1 68", inst_resp, inst_addr);
    else passed++;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (!(inst_read === 1'b0 && if_valid === 1'b0 && fifo_count === 3'd0))
      $display("FAIL rr_drop rd %b v %b cnt %0d exp 0 0 0", inst_read, if_valid, fifo_count);
    else passed++;
    tick();
    checks++;
    if (!(inst_read === 1'b1 && inst_addr === 32'h200))
      $display("FAIL rr_reissue rd %b addr %h exp 1 200", inst_read, inst_addr);
    else passed++;
    tick();
    checks++;
    if (!(if_valid === 1'b1 && if_pc === 32'h200))
      $display("FAIL rr_first v %b pc %h exp 1 200", if_valid, if_pc);
    else passed++;
  endtask

  task automatic test_full_pop();
    int n;
    logic [31:0] exp;
    do_reset(0, 1'b0);
    n = 0;
    while (fifo_count !== 3'd4 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (fifo_count !== 3'd4) $display("FAIL fp_fill got %0d exp 4", fifo_count);
    else passed++;
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    checks++;
    if (!(fifo_count === 3'd3 && if_pc === 32'h64 && inst_read === 1'b0))
      $display("FAIL fp_pop cnt %0d pc %h rd %b exp 3 64 0", fifo_count, if_pc, inst_read);
    else passed++;
    tick();
    checks++;
    if (!(inst_read === 1'b1 && inst_addr === 32'h70 && fifo_count === 3'd3))
      $display("FAIL fp_refill rd %b addr %h cnt %0d exp 1 70 3", inst_read, inst_addr, fifo_count);
    else passed++;
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp = 32'h68 + 32'(4 * i);
      checks++;
      if (!(fifo_count === 3'd3 && if_valid === 1'b1 && if_pc === exp))
        $display("FAIL fp_pushpop cnt %0d pc %h exp 3 %h", fifo_count, if_pc, exp);
      else passed++;
    end
  endtask

  task automatic test_double_redirect();
    int n;
    do_reset(3, 1'b1);
    tick();
    checks++;
    if (!(inst_read === 1'b1 && inst_resp === 1'b0))
      $display("FAIL dr_setup rd %b resp %b exp 1 0", inst_read, inst_resp);
    else passed++;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    tick();
    redirect_pc = 32'h400;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (!(inst_read === 1'b1 && fifo_count === 3'd0 && if_valid === 1'b0))
      $display("FAIL dr_discard rd %b cnt %0d v %b exp 1 0 0", inst_read, fifo_count, if_valid);
    else passed++;
    n = 0;
    while (if_valid !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (!(if_valid === 1'b1 && if_pc === 32'h400 && if_instr === (32'h400 ^ KEY)))
      $display("FAIL dr_first v %b pc %h ins %h exp 1 400", if_valid, if_pc, if_instr);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset(0, 1'b0);
    n = 0;
    while (fifo_count !== 3'd2 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!(fifo_count === 3'd2 && inst_read === 1'b1))
      $display("FAIL rm_setup cnt %0d rd %b exp 2 1", fifo_count, inst_read);
    else passed++;
    rst = 1'b1;
    tick();
    checks++;
    if (!(inst_read === 1'b0 && fifo_count === 3'd0))
      $display("FAIL rm_clear rd %b cnt %0d exp 0 0", inst_read, fifo_count);
    else passed++;
    checks++;
    if (!(if_instr === 32'h13 && if_valid === 1'b0))
      $display("FAIL rm_nop ins %h v %b exp 13 0", if_instr, if_valid);
    else passed++;
    rst = 1'b0;
    n   = 0;
    while (inst_read !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (!(inst_read === 1'b1 && inst_addr === 32'h60))
      $display("FAIL rm_restart rd %b addr %h exp 1 60", inst_read, inst_addr);
    else passed++;
  endtask

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b0;
    inst_resp      = 1'b0;
    inst_rdata     = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_pending();
    test_redirect_resp();
    test_full_pop();
    test_double_redirect();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1);
  end

endmodule
